mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control FSM; sequences the shared 32-bit registered ALU, PC, IR, register file and memory port.
//  One instruction per FETCH..writeback pass. Sits beside the datapath and drives every mux select and enable.
//  The ALU also performs PC+4 and the branch-target add.
//  ALU result is registered (valid the cycle after select/operands are applied); ALU zero is combinational (A==B).

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mips_multicycle_ctrl_alu_func_decode.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path:
// opcodes, functs, ALU selects, mux encodings and FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SA_PC   = 2'b00;
    localparam logic [1:0] SA_A    = 2'b01;
    localparam logic [1:0] SA_RES  = 2'b10;
    localparam logic [1:0] SB_B    = 2'b00;
    localparam logic [1:0] SB_4    = 2'b01;
    localparam logic [1:0] SB_IMM  = 2'b10;
    localparam logic [1:0] SB_IMM2 = 2'b11;
    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_func_decode.sv
// R-type funct to ALU select; also flags unsupported functs.
module alu_func_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_sel,
    output logic       legal
);

    always_comb begin
        alu_sel = ALU_ADD;
        legal   = 1'b1;
        case (funct)
            FN_ADD:  alu_sel = ALU_ADD;
            FN_SUB:  alu_sel = ALU_SUB;
            FN_AND:  alu_sel = ALU_AND;
            FN_OR:   alu_sel = ALU_OR;
            FN_SLT:  alu_sel = ALU_SLT;
            FN_NOR:  alu_sel = ALU_NOR;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences ALU, PC, IR, register
// file and memory port, one instruction per FETCH..writeback pass.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_sel,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t     state;
    state_t     next;
    logic [3:0] fn_sel;
    logic       fn_legal;

    alu_func_decode u_fdec (
        .funct   (funct),
        .alu_sel (fn_sel),
        .legal   (fn_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    assign state_dbg = state;

    // Outputs are forced low while reset is asserted, even in FETCH.
    always_comb begin
        next          = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_source     = PC_ALU;
        alu_src_a     = SA_PC;
        alu_src_b     = SB_B;
        alu_sel       = ALU_AND;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SB_4;
                    alu_sel   = ALU_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        next     = S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc_en     = 1'b1;
                    alu_src_a = SA_RES;
                    alu_src_b = SB_IMM2;
                    alu_sel   = ALU_ADD;
                    case (opcode)
                        OP_RTYPE: illegal_instr = !fn_legal;
                        OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ;
                        default:  illegal_instr = 1'b1;
                    endcase
                    if (illegal_instr)
                        next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                    else if (opcode == OP_RTYPE) next = S_EXEC_R;
                    else if (opcode == OP_BEQ)   next = S_BRANCH;
                    else if (opcode == OP_J)     next = S_JUMP;
                    else if (opcode == OP_ADDI)  next = S_ADDI_EX;
                    else                         next = S_MEM_ADDR;
                end
                S_EXEC_R, S_R_WB: begin
                    alu_src_a = SA_A;
                    alu_sel   = fn_sel;
                    if (state == S_R_WB) begin
                        reg_write = 1'b1;
                        reg_dst   = 1'b1;
                        next      = S_FETCH;
                    end else begin
                        next = S_R_WB;
                    end
                end
                // Address selects stay up so the result register holds.
                S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE: begin
                    alu_src_a = SA_A;
                    alu_src_b = SB_IMM;
                    alu_sel   = ALU_ADD;
                    unique case (state)
                        S_MEM_ADDR:
                            next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                        S_MEM_READ: begin
                            mem_read = 1'b1;
                            iord     = 1'b1;
                            if (mem_ready) next = S_MEM_WB;
                        end
                        S_MEM_WRITE: begin
                            mem_write = 1'b1;
                            iord      = 1'b1;
                            if (mem_ready) next = S_FETCH;
                        end
                        default: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 1'b1;
                            next       = S_FETCH;
                        end
                    endcase
                end
                S_BRANCH: begin
                    alu_src_a = SA_A;
                    alu_sel   = ALU_SUB;
                    pc_source = PC_BR;
                    pc_en     = zero;
                    next      = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = PC_JMP;
                    pc_en     = 1'b1;
                    next      = S_FETCH;
                end
                S_ADDI_EX, S_ADDI_WB: begin
                    alu_src_a = SA_A;
                    alu_src_b = SB_IMM;
                    alu_sel   = ALU_ADD;
                    if (state == S_ADDI_WB) begin
                        reg_write = 1'b1;
                        next      = S_FETCH;
                    end else begin
                        next = S_ADDI_WB;
                    end
                end
                S_TRAP: next = S_TRAP;
                default: next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle control FSM; a second
// instance with ILLEGAL_TRAP=1 shares the stimulus.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_a, alu_src_b;
    logic [3:0] alu_sel, state_dbg;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr;

    logic       mem_read_t, mem_write_t, iord_t, ir_write_t, pc_en_t;
    logic [1:0] pc_source_t, alu_src_a_t, alu_src_b_t;
    logic [3:0] alu_sel_t, state_dbg_t;
    logic       reg_write_t, reg_dst_t, mem_to_reg_t, illegal_instr_t;

    logic [18:0] outs, outs_t;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n0;

    always #5 clk = ~clk;

    assign outs = {mem_read, mem_write, iord, ir_write, pc_en, pc_source,
                   alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
                   mem_to_reg, illegal_instr};
    assign outs_t = {mem_read_t, mem_write_t, iord_t, ir_write_t, pc_en_t,
                     pc_source_t, alu_src_a_t, alu_src_b_t, alu_sel_t,
                     reg_write_t, reg_dst_t, mem_to_reg_t, illegal_instr_t};

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read_t), .mem_write(mem_write_t), .iord(iord_t),
        .ir_write(ir_write_t), .pc_en(pc_en_t), .pc_source(pc_source_t),
        .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
        .alu_sel(alu_sel_t), .reg_write(reg_write_t), .reg_dst(reg_dst_t),
        .mem_to_reg(mem_to_reg_t), .illegal_instr(illegal_instr_t),
        .state_dbg(state_dbg_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // FETCH with memory ready, then step into DECODE.
    task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        n0        = cyc;
        #1;
        chk("f_state", state_dbg, S_FETCH);
        chk("f_mrd", mem_read, 1);
        chk("f_irw", ir_write, 1);
        chk("f_pcen", pc_en, 0);
        chk("f_alu", {alu_src_a, alu_src_b, alu_sel}, 8'b00_01_0010);
        tick();
        chk("d_state", state_dbg, S_DECODE);
        chk("d_pcen", pc_en, 1);
        chk("d_alu", {pc_source, alu_src_a, alu_src_b, alu_sel},
            10'b00_10_11_0010);
    endtask

    task automatic r_type(input logic [5:0] fn, input logic [3:0] sel,
                          input string tag);
        fetch_dec(OP_RTYPE, fn);
        chk({tag, "_ill"}, illegal_instr, 0);
        tick();
        chk({tag, "_ex"}, state_dbg, S_EXEC_R);
        chk({tag, "_sel"}, {alu_src_a, alu_src_b, alu_sel},
            {4'b01_00, sel});
        tick();
        chk({tag, "_wb"}, state_dbg, S_R_WB);
        chk({tag, "_wbsig"}, {reg_write, reg_dst, mem_to_reg}, 3'b110);
        chk({tag, "_wbsel"}, alu_sel, sel);
        tick();
        chk({tag, "_cyc"}, cyc - n0, 4);
        chk({tag, "_back"}, state_dbg, S_FETCH);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'd0; funct = 6'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_outs", outs, 0);
        chk("rst_state", state_dbg, S_FETCH);
        chk("rst_outs_t", outs_t, 0);
        rst_n = 1'b1;
        tick();

        // FETCH holds while memory is not ready
        mem_ready = 1'b0;
        #1;
        chk("fw_mrd", {mem_read, iord, ir_write}, 3'b100);
        tick();
        chk("fw_state", state_dbg, S_FETCH);

        r_type(FN_ADD, ALU_ADD, "add");

        // lw with two wait cycles
        fetch_dec(OP_LW, 6'd0);
        tick();
        chk("lw_addr", state_dbg, S_MEM_ADDR);
        chk("lw_asel", {alu_src_a, alu_src_b, alu_sel}, 8'b01_10_0010);
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            #1;
            chk("lw_rd", state_dbg, S_MEM_READ);
            chk("lw_rdsig", {mem_read, iord, ir_write}, 3'b110);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_rdy", {mem_read, iord, ir_write}, 3'b110);
        tick();
        chk("lw_wb", state_dbg, S_MEM_WB);
        chk("lw_wbsig", {reg_write, reg_dst, mem_to_reg}, 3'b101);
        tick();
        chk("lw_cyc", cyc - n0, 7);

        // beq taken then not taken
        for (int i = 0; i < 2; i++) begin
            fetch_dec(OP_BEQ, 6'd0);
            tick();
            zero = (i == 0);
            #1;
            chk("beq_state", state_dbg, S_BRANCH);
            chk("beq_pc", {pc_en, pc_source}, (i == 0) ? 3'b101 : 3'b001);
            chk("beq_sel", {alu_src_a, alu_src_b, alu_sel}, 8'b01_00_0110);
            tick();
            chk("beq_cyc", cyc - n0, 3);
        end
        zero = 1'b0;

        fetch_dec(OP_J, 6'd0);
        tick();
        chk("j_state", state_dbg, S_JUMP);
        chk("j_pc", {pc_en, pc_source}, 3'b110);
        tick();
        chk("j_cyc", cyc - n0, 3);

        fetch_dec(OP_ADDI, 6'd0);
        tick();
        chk("addi_ex", state_dbg, S_ADDI_EX);
        chk("addi_sel", {alu_src_a, alu_src_b, alu_sel}, 8'b01_10_0010);
        tick();
        chk("addi_wb", {reg_write, reg_dst, mem_to_reg}, 3'b100);
        chk("addi_wbsel", {alu_src_a, alu_src_b, alu_sel}, 8'b01_10_0010);
        tick();
        chk("addi_cyc", cyc - n0, 4);

        r_type(FN_NOR, ALU_NOR, "nor");
        r_type(FN_SLT, ALU_SLT, "slt");
        r_type(FN_SUB, ALU_SUB, "sub");

        // illegal funct: refetch vs trap
        fetch_dec(OP_RTYPE, 6'b000000);
        chk("fn0_ill", illegal_instr, 1);
        chk("fn0_ill_t", illegal_instr_t, 1);
        tick();
        chk("fn0_state", state_dbg, S_FETCH);
        chk("fn0_pulse", illegal_instr, 0);
        chk("fn0_trap", state_dbg_t, S_TRAP);
        chk("fn0_trap_outs", outs_t, 0);

        fetch_dec(6'b111111, 6'd0);
        chk("op3f_ill", illegal_instr, 1);
        tick();
        chk("op3f_state", state_dbg, S_FETCH);
        chk("op3f_pulse", illegal_instr, 0);
        chk("op3f_trap", state_dbg_t, S_TRAP);

        // sw with one wait cycle
        fetch_dec(OP_SW, 6'd0);
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_state", state_dbg, S_MEM_WRITE);
        chk("sw_sig", {mem_write, mem_read, iord}, 3'b101);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("sw_hold", state_dbg, S_MEM_WRITE);
        tick();
        chk("sw_cyc", cyc - n0, 5);

        // reset in MEM_WRITE aborts the store
        fetch_dec(OP_SW, 6'd0);
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("swr_mw", mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("swr_drop", mem_write, 0);
        chk("swr_outs", outs, 0);
        chk("swr_state", state_dbg, S_FETCH);
        chk("swr_trap", state_dbg_t, S_FETCH);
        tick();
        rst_n = 1'b1;
        tick();
        chk("swr_after", state_dbg, S_FETCH);
        chk("swr_after_t", state_dbg_t, S_FETCH);
        chk("swr_mrd", mem_read, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
